// File: rtl/pool_rf_pkg.sv
// Shared types, port-count limits and the max-compare helper for the pooling register file.
package pool_rf_pkg;

    typedef enum logic {
        WR_OVERWRITE = 1'b0,
        WR_MAX       = 1'b1
    } wr_mode_e;

    localparam int unsigned MIN_NUM_WR     = 1;
    localparam int unsigned MAX_NUM_WR     = 4;
    localparam int unsigned MIN_NUM_RD     = 1;
    localparam int unsigned MAX_NUM_RD     = 8;
    localparam int unsigned MAX_DATA_WIDTH = 32;

    // Operands are zero-extended by the caller; shifting left aligns their sign bit at the MSB.
    function automatic logic [MAX_DATA_WIDTH-1:0] pool_max(
        input logic [MAX_DATA_WIDTH-1:0] a,
        input logic [MAX_DATA_WIDTH-1:0] b,
        input logic                      is_signed,
        input int unsigned               width
    );
        logic [MAX_DATA_WIDTH-1:0] a_al;
        logic [MAX_DATA_WIDTH-1:0] b_al;
        logic                      a_ge;
        a_al = a << (MAX_DATA_WIDTH - width);
        b_al = b << (MAX_DATA_WIDTH - width);
        if (is_signed) begin
            a_ge = $signed(a_al) >= $signed(b_al);
        end else begin
            a_ge = a_al >= b_al;
        end
        return a_ge ? a : b;
    endfunction

endpackage

// File: rtl/pool_rf_merge.sv
// Per-entry write-merge chain: folds every enabled, address-matching port into the entry in port order.
module pool_rf_merge
    import pool_rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned SIGNED     = 1
) (
    input  logic [DATA_WIDTH-1:0]        cur_data,
    input  logic                         cur_valid,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR-1:0]            wr_mode,
    input  logic [NUM_WR-1:0]            hit,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0]        next_data_c,
    output logic                         next_valid_c
);

    logic [DATA_WIDTH-1:0] d;
    logic                  v;

    // Higher ports see the lower ports' result, so a late overwrite wins and max ports accumulate.
    always_comb begin
        d = cur_data;
        v = cur_valid;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && hit[i]) begin
                if ((wr_mode[i] == 1'(WR_MAX)) && v) begin
                    d = DATA_WIDTH'(pool_max(MAX_DATA_WIDTH'(d),
                                             MAX_DATA_WIDTH'(wr_data[i*DATA_WIDTH +: DATA_WIDTH]),
                                             SIGNED != 0, DATA_WIDTH));
                end else begin
                    d = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
                v = 1'b1;
            end
        end
        next_data_c  = d;
        next_valid_c = v;
    end

endmodule

// File: rtl/pool_regfile_mp.sv
// Multi-port pooling register file with per-port overwrite/max-accumulate writes and valid tracking.
module pool_regfile_mp
    import pool_rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH),
    parameter int unsigned NUM_WR       = 2,
    parameter int unsigned NUM_RD       = 4,
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned SIGNED       = 1
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         clr,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR-1:0]            wr_mode,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic                         wr_collision
);

    if (NUM_WR < MIN_NUM_WR || NUM_WR > MAX_NUM_WR) begin : g_bad_num_wr
        $error("pool_regfile_mp: NUM_WR out of range");
    end
    if (NUM_RD < MIN_NUM_RD || NUM_RD > MAX_NUM_RD) begin : g_bad_num_rd
        $error("pool_regfile_mp: NUM_RD out of range");
    end
    if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("pool_regfile_mp: DATA_WIDTH too large");
    end

    logic [DATA_WIDTH-1:0]     mem        [DEPTH];
    logic [DEPTH-1:0]          valid;
    logic [NUM_WR-1:0]         addr_hit   [DEPTH];
    logic [DATA_WIDTH-1:0]     next_data  [DEPTH];
    logic [DEPTH-1:0]          next_valid;
    logic                      collision_c;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
    logic [NUM_RD-1:0]            rd_valid_c;

    // Address decode; an out-of-range address matches no entry, so it neither writes nor collides.
    always_comb begin
        collision_c = 1'b0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            addr_hit[e] = '0;
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                addr_hit[e][i] = (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e));
            end
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                for (int unsigned j = i + 1; j < NUM_WR; j++) begin
                    if (wr_en[i] && wr_en[j] && addr_hit[e][i] && addr_hit[e][j]) begin
                        collision_c = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        pool_rf_merge #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WR     (NUM_WR),
            .SIGNED     (SIGNED)
        ) u_merge (
            .cur_data     (mem[e]),
            .cur_valid    (valid[e]),
            .wr_en        (wr_en),
            .wr_mode      (wr_mode),
            .hit          (addr_hit[e]),
            .wr_data      (wr_data),
            .next_data_c  (next_data[e]),
            .next_valid_c (next_valid[e])
        );
    end

    // Storage; clr drops every write of its cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
            valid <= '0;
        end else if (clr) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
            valid <= '0;
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                mem[e] <= next_data[e];
            end
            valid <= next_valid;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= collision_c;
        end
    end

    // AND-OR read mux from stored state; unmatched addresses read as zero/invalid.
    always_comb begin
        rd_data_c  = '0;
        rd_valid_c = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(e)) begin
                    rd_data_c[p*DATA_WIDTH +: DATA_WIDTH] = mem[e];
                    rd_valid_c[p]                         = valid[e];
                end
            end
        end
    end

    if (READ_LATENCY == 0) begin : g_rd_comb
        assign rd_data  = rd_data_c;
        assign rd_valid = rd_valid_c;
    end else begin : g_rd_reg
        // Captures pre-edge contents, giving read-before-write even against clr.
        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                rd_data  <= '0;
                rd_valid <= '0;
            end else begin
                rd_data  <= rd_data_c;
                rd_valid <= rd_valid_c;
            end
        end
    end

endmodule
